// File: rtl/count_enable_gen_pkg.sv
// Shared types and default widths for the count-enable generator.
package count_enable_pkg;

  localparam int DEFAULT_DIV_W   = 8;
  localparam int DEFAULT_BURST_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_enable_gen_if.sv
// Control/status bundle between a controller and the count-enable generator.
interface count_enable_if
  import count_enable_pkg::*;
#(
  parameter int DIV_W   = DEFAULT_DIV_W,
  parameter int BURST_W = DEFAULT_BURST_W
);

  logic               start;
  logic               stop;
  logic               pause;
  logic [DIV_W-1:0]   div;
  logic [BURST_W-1:0] burst;
  logic               en;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] issued;

  modport master (
    output start, stop, pause, div, burst,
    input  en, busy, done, issued
  );

  modport slave (
    input  start, stop, pause, div, burst,
    output en, busy, done, issued
  );

endinterface

// File: rtl/count_enable_gen_prescaler.sv
// Free-running divide-by-(div_q+1) prescaler; wrap marks the terminal count.
module en_prescaler
  import count_enable_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             hold,
  input  logic [DIV_W-1:0] div_q,
  output logic             wrap
);

  logic [DIV_W-1:0] cnt;

  assign wrap = (cnt == div_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_enable_gen.sv
// Burst/continuous enable-pulse generator: run/pause/stop FSM plus issued counter.
module count_enable_gen
  import count_enable_pkg::*;
#(
  parameter int DIV_W   = DEFAULT_DIV_W,
  parameter int BURST_W = DEFAULT_BURST_W
) (
  input logic         clk,
  input logic         rst,
  count_enable_if.slave bus
);

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] issued, issued_n;
  logic               en_q, en_n;
  logic               done_q, done_n;
  logic               load;
  logic               wrap;
  logic               advance;

  // The prescaler only moves on edges where a run is active and neither pause nor stop is asserted.
  assign advance = ((state == RUN) || (state == PAUSE)) && !bus.stop && !bus.pause;

  en_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == IDLE),
    .hold  (!advance),
    .div_q (div_q),
    .wrap  (wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    issued_n = issued;
    en_n     = 1'b0;
    done_n   = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_n  = RUN;
          issued_n = '0;
          load     = 1'b1;
        end
      end
      RUN, PAUSE: begin
        if (bus.stop) begin
          state_n = IDLE;
        end else if (bus.pause) begin
          state_n = PAUSE;
        end else begin
          state_n = RUN;
          if (wrap) begin
            en_n     = 1'b1;
            issued_n = issued + 1'b1;
            if ((burst_q != '0) && (issued_n == burst_q)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      burst_q <= '0;
      issued  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      if (load) begin
        div_q   <= bus.div;
        burst_q <= bus.burst;
      end
      issued <= issued_n;
      en_q   <= en_n;
      done_q <= done_n;
    end
  end

  assign bus.en     = en_q;
  assign bus.done   = done_q;
  assign bus.issued = issued;
  assign bus.busy   = (state != IDLE);

endmodule

// File: tb/tb_count_enable_gen.sv
// Directed and random checks of count_enable_gen against a tick-counting reference model.
module tb_count_enable_gen;

  localparam int DIV_W   = 8;
  localparam int BURST_W = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  count_enable_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus();

  count_enable_gen #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a run is a count of un-paused edges since start; a pulse lands every (div+1) of them.
  bit m_running, m_finishing, exp_en, exp_done;
  int m_ticks, m_pulses, m_div, m_burst;

  function automatic void modelReset();
    m_running   = 1'b0;
    m_finishing = 1'b0;
    exp_en      = 1'b0;
    exp_done    = 1'b0;
    m_ticks     = 0;
    m_pulses    = 0;
    m_div       = 0;
    m_burst     = 0;
  endfunction

  function automatic void modelEdge(bit s, bit st, bit p, int d, int b);
    exp_en   = 1'b0;
    exp_done = 1'b0;
    if (m_finishing) begin
      m_finishing = 1'b0;
    end else if (m_running) begin
      if (st) begin
        m_running = 1'b0;
      end else if (!p) begin
        m_ticks++;
        if (m_ticks % (m_div + 1) == 0) begin
          exp_en = 1'b1;
          m_pulses++;
          if (m_burst != 0 && m_pulses == m_burst) begin
            m_running   = 1'b0;
            m_finishing = 1'b1;
            exp_done    = 1'b1;
          end
        end
      end
    end else if (s && !st) begin
      m_running = 1'b1;
      m_ticks   = 0;
      m_pulses  = 0;
      m_div     = d;
      m_burst   = b;
    end
  endfunction

  task automatic checkOutput(string tag);
    logic [BURST_W-1:0] exp_issued;
    logic exp_busy;
    exp_issued = BURST_W'(m_pulses % (1 << BURST_W));
    exp_busy   = m_running || m_finishing;
    checks++;
    assert (bus.en === exp_en) else begin
      errors++;
      $error("[TB] FAIL %s en: got %b want %b", tag, bus.en, exp_en);
    end
    checks++;
    assert (bus.done === exp_done) else begin
      errors++;
      $error("[TB] FAIL %s done: got %b want %b", tag, bus.done, exp_done);
    end
    checks++;
    assert (bus.busy === exp_busy) else begin
      errors++;
      $error("[TB] FAIL %s busy: got %b want %b", tag, bus.busy, exp_busy);
    end
    checks++;
    assert (bus.issued === exp_issued) else begin
      errors++;
      $error("[TB] FAIL %s issued: got %0d want %0d", tag, bus.issued, exp_issued);
    end
  endtask

  task automatic applyStimulus(bit s, bit st, bit p, int d, int b, string tag);
    bus.start = s;
    bus.stop  = st;
    bus.pause = p;
    bus.div   = d[DIV_W-1:0];
    bus.burst = b[BURST_W-1:0];
    @(posedge clk);
    modelEdge(s, st, p, d, b);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    bit got;
    int gap;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    bus.div   = '0;
    bus.burst = '0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput("reset");
    rst = 1'b0;

    $display("[TB] div=3 burst=2 single burst");
    applyStimulus(1, 0, 0, 3, 2, "b32_start");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 3, 2, "b32_run");

    $display("[TB] div=0 continuous with wrap, then stop");
    applyStimulus(1, 0, 0, 0, 0, "cont_start");
    for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0, "cont_run");
    applyStimulus(0, 1, 0, 0, 0, "cont_stop");
    applyStimulus(0, 0, 0, 0, 0, "cont_idle");

    $display("[TB] div=4 burst=3 with a 5-cycle pause");
    applyStimulus(1, 0, 0, 4, 3, "pause_start");
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      applyStimulus(0, 0, 0, 4, 3, "pause_first");
      if (bus.en === 1'b1) got = 1'b1;
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("[TB] FAIL pause_first_en: got %b want 1", got);
    end
    gap = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 4, 3, "pause_hold");
      gap++;
      checks++;
      assert (bus.issued === 4'd1) else begin
        errors++;
        $error("[TB] FAIL pause_issued_hold: got %0d want 1", bus.issued);
      end
    end
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      applyStimulus(0, 0, 0, 4, 3, "pause_resume");
      gap++;
      if (bus.en === 1'b1) got = 1'b1;
    end
    checks++;
    assert (got && gap == 10) else begin
      errors++;
      $error("[TB] FAIL pause_gap: got %0d want 10", gap);
    end
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 4, 3, "pause_tail");

    $display("[TB] div=2 burst=5 aborted by async reset");
    applyStimulus(1, 0, 0, 2, 5, "rst_start");
    for (int i = 0; i < 20 && m_pulses < 2; i++) applyStimulus(0, 0, 0, 2, 5, "rst_run");
    #3;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("rst_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 2, 5, "rst_after");

    $display("[TB] start+stop in idle, restart attempt while running");
    applyStimulus(1, 1, 0, 2, 0, "ss_idle");
    applyStimulus(1, 0, 0, 2, 0, "rs_start");
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 2, 0, "rs_run");
    applyStimulus(1, 0, 0, 7, 0, "rs_restart");
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 0, 7, 0, "rs_keep");
    applyStimulus(0, 1, 1, 7, 0, "rs_stop_pause");
    applyStimulus(0, 0, 0, 7, 0, "rs_idle");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(3) == 0, $urandom_range(15) == 0, $urandom_range(5) == 0,
                    int'($urandom_range(5)), int'($urandom_range(5)), "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
